// File: rtl/barrel_rotate_sequencer_pkg.sv
// Shared definitions for the barrel rotate sequencer: state encoding,
// rotator direction codes, rotator step limit and word width.
package barrel_rotate_sequencer_pkg;

    localparam int ROT_W        = 8;
    localparam int ROT_MAX_STEP = 3;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] ROTATE_ENC = 2'd1;
    localparam logic [1:0] DONE_ENC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = IDLE_ENC,
        ROTATE = ROTATE_ENC,
        DONE   = DONE_ENC
    } seq_state_e;

    // Largest step the rotator may take from the remaining distance.
    function automatic logic [2:0] step_mag(input logic [2:0] remaining);
        logic [2:0] step;
        if (remaining > 3'(ROT_MAX_STEP)) begin
            step = 3'(ROT_MAX_STEP);
        end else begin
            step = remaining;
        end
        return step;
    endfunction

endpackage

// File: rtl/barrel_rotate_sequencer_rot_amount_norm.sv
// Normalises a rotate request to an effective distance 0..7 and direction.
// With OPTIMIZE set, distances 5..7 flip direction and become 8-a, so the
// effective distance never exceeds 4.
module barrel_rotate_sequencer_rot_amount_norm
    import barrel_rotate_sequencer_pkg::*;
#(
    parameter int AMT_W    = 4,
    parameter int OPTIMIZE = 1
) (
    input  logic [AMT_W-1:0] amount,
    input  logic             dir_in,
    output logic [2:0]       eff,
    output logic             dir_out
);

    logic [2:0] amt_mod_s;
    logic       unused_amount_s;

    // Only the low three bits matter: rotating an 8-bit word is mod 8.
    assign amt_mod_s       = amount[2:0];
    assign unused_amount_s = ^amount;

    // Pick the shorter way round when optimisation is enabled.
    always_comb begin
        eff     = amt_mod_s;
        dir_out = dir_in;
        if ((OPTIMIZE != 0) && (amt_mod_s > 3'd4)) begin
            eff     = 3'd0 - amt_mod_s;
            dir_out = ~dir_in;
        end else begin
            eff     = amt_mod_s;
            dir_out = dir_in;
        end
    end

endmodule

// File: rtl/barrel_rotate_sequencer.sv
// Control stage in front of an external 8-bit rotator that can move at most
// three positions per pass. Accepts one request, drives the rotator one step
// per cycle, captures its result and offers the finished word downstream.
module barrel_rotate_sequencer
    import barrel_rotate_sequencer_pkg::*;
#(
    parameter int AMT_W    = 4,
    parameter int OPTIMIZE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic [AMT_W-1:0] s_amount,
    input  logic             s_dir,
    output logic [7:0]       rot_in,
    output logic [2:0]       rot_mag,
    output logic             rot_dir,
    input  logic [7:0]       rot_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic [1:0]       m_passes
);

    seq_state_e       state_q, state_d;
    logic [ROT_W-1:0] work_q, work_d;
    logic [2:0]       remain_q, remain_d;
    logic             dir_q, dir_d;
    logic [1:0]       pass_q, pass_d;

    logic [2:0]       norm_eff_s;
    logic             norm_dir_s;
    logic [2:0]       step_s;
    logic [2:0]       remain_next_s;

    barrel_rotate_sequencer_rot_amount_norm #(
        .AMT_W    (AMT_W),
        .OPTIMIZE (OPTIMIZE)
    ) u_norm (
        .amount  (s_amount),
        .dir_in  (s_dir),
        .eff     (norm_eff_s),
        .dir_out (norm_dir_s)
    );

    assign step_s        = step_mag(remain_q);
    assign remain_next_s = remain_q - step_s;

    // Next-state and output decode; all outputs derive from registered state.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        pass_d   = pass_q;
        s_ready  = 1'b0;
        rot_in   = work_q;
        rot_mag  = 3'd0;
        rot_dir  = DIR_RIGHT;
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_passes = 2'd0;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    work_d   = s_data;
                    remain_d = norm_eff_s;
                    dir_d    = norm_dir_s;
                    pass_d   = 2'd0;
                    if (norm_eff_s != 3'd0) begin
                        state_d = ROTATE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ROTATE: begin
                rot_mag  = step_s;
                rot_dir  = dir_q;
                work_d   = rot_out;
                remain_d = remain_next_s;
                pass_d   = pass_q + 2'd1;
                if (remain_next_s == 3'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = ROTATE;
                end
            end
            DONE: begin
                m_valid  = 1'b1;
                m_data   = work_q;
                m_passes = pass_q;
                if (m_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset drops any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= 8'h00;
            remain_q <= 3'd0;
            dir_q    <= DIR_RIGHT;
            pass_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
            pass_q   <= pass_d;
        end
    end

endmodule

// File: tb/tb_barrel_rotate_sequencer.sv
// Bench for barrel_rotate_sequencer: two instances (OPTIMIZE=1 and 0) share
// the request/consumer inputs, each driving its own behavioural rotator.
module tb_barrel_rotate_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, s_valid, s_dir, m_ready;
    logic [7:0] s_data;
    logic [3:0] s_amount;

    logic       s_ready_1, rot_dir_1, m_valid_1;
    logic [7:0] rot_in_1, rot_out_1, m_data_1;
    logic [2:0] rot_mag_1;
    logic [1:0] m_passes_1;

    logic       s_ready_0, rot_dir_0, m_valid_0;
    logic [7:0] rot_in_0, rot_out_0, m_data_0;
    logic [2:0] rot_mag_0;
    logic [1:0] m_passes_0;

    int checks = 0;
    int errors = 0;

    // Behavioural rotator: dir 0 right, 1 left, magnitudes 4..7 act as 3.
    function automatic logic [7:0] rot_model(input logic [7:0] d, input logic dir,
                                             input logic [2:0] mag);
        logic [15:0] dd;
        logic [15:0] sh;
        logic [2:0]  m;
        logic [7:0]  r;
        m  = (mag > 3'd3) ? 3'd3 : mag;
        dd = {d, d};
        if (dir) begin
            sh = dd << m;
            r  = sh[15:8];
        end else begin
            sh = dd >> m;
            r  = sh[7:0];
        end
        return r;
    endfunction

    assign rot_out_1 = rot_model(rot_in_1, rot_dir_1, rot_mag_1);
    assign rot_out_0 = rot_model(rot_in_0, rot_dir_0, rot_mag_0);

    barrel_rotate_sequencer #(.AMT_W(4), .OPTIMIZE(1)) u_opt1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_1),
        .s_data(s_data), .s_amount(s_amount), .s_dir(s_dir),
        .rot_in(rot_in_1), .rot_mag(rot_mag_1), .rot_dir(rot_dir_1), .rot_out(rot_out_1),
        .m_valid(m_valid_1), .m_ready(m_ready), .m_data(m_data_1), .m_passes(m_passes_1)
    );

    barrel_rotate_sequencer #(.AMT_W(4), .OPTIMIZE(0)) u_opt0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_0),
        .s_data(s_data), .s_amount(s_amount), .s_dir(s_dir),
        .rot_in(rot_in_0), .rot_mag(rot_mag_0), .rot_dir(rot_dir_0), .rot_out(rot_out_0),
        .m_valid(m_valid_0), .m_ready(m_ready), .m_data(m_data_0), .m_passes(m_passes_0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-pass trace nibble is {rot_dir, rot_mag}, oldest pass in the high nibble.
    typedef struct {
        logic [7:0]  data;
        logic [3:0]  amt;
        logic        dir;
        logic [7:0]  exp;
        logic [1:0]  p1;
        logic [1:0]  p0;
        logic [15:0] seq1;
        logic [15:0] seq0;
    } vec_t;

    vec_t vecs[10];

    // One request end to end; hold > 0 keeps m_ready low that many extra cycles.
    task automatic run_req(input vec_t v, input int hold, input string tag);
        int          lat1, lat0;
        logic [15:0] seq1, seq0;
        logic        busy_ready, idle_mag;
        lat1 = 0; lat0 = 0; seq1 = 16'h0; seq0 = 16'h0;
        busy_ready = 1'b0; idle_mag = 1'b0;
        @(negedge clk);
        chk({tag, " s_ready before"}, {s_ready_1, s_ready_0}, 2'b11);
        s_valid  = 1'b1;
        s_data   = v.data;
        s_amount = v.amt;
        s_dir    = v.dir;
        m_ready  = 1'b0;
        @(posedge clk);
        #1;
        // Keep offering a different request while busy; it must be ignored.
        s_data   = 8'hFF;
        s_amount = 4'd3;
        s_dir    = ~v.dir;
        for (int k = 1; k <= 8; k++) begin
            if (s_ready_1 || s_ready_0) busy_ready = 1'b1;
            if (lat1 == 0 && m_valid_1) lat1 = k;
            if (lat0 == 0 && m_valid_0) lat0 = k;
            if (lat1 == 0) seq1 = (seq1 << 4) | {12'h0, rot_dir_1, rot_mag_1};
            else if (rot_mag_1 != 3'd0) idle_mag = 1'b1;
            if (lat0 == 0) seq0 = (seq0 << 4) | {12'h0, rot_dir_0, rot_mag_0};
            else if (rot_mag_0 != 3'd0) idle_mag = 1'b1;
            if (lat1 != 0 && lat0 != 0) break;
            @(posedge clk);
            #1;
        end
        chk({tag, " latency opt1"}, lat1, 32'(v.p1) + 32'd1);
        chk({tag, " latency opt0"}, lat0, 32'(v.p0) + 32'd1);
        chk({tag, " passes trace opt1"}, seq1, v.seq1);
        chk({tag, " passes trace opt0"}, seq0, v.seq0);
        chk({tag, " s_ready low while busy"}, busy_ready, 1'b0);
        chk({tag, " rot_mag zero outside ROTATE"}, idle_mag, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold m_valid"}, {m_valid_1, m_valid_0}, 2'b11);
            chk({tag, " hold m_data opt1"}, m_data_1, v.exp);
            chk({tag, " hold m_data opt0"}, m_data_0, v.exp);
            chk({tag, " hold m_passes"}, {m_passes_1, m_passes_0}, {v.p1, v.p0});
        end
        chk({tag, " m_data opt1"}, m_data_1, v.exp);
        chk({tag, " m_data opt0"}, m_data_0, v.exp);
        chk({tag, " m_passes opt1"}, m_passes_1, v.p1);
        chk({tag, " m_passes opt0"}, m_passes_0, v.p0);
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " m_valid after pop"}, {m_valid_1, m_valid_0}, 2'b00);
        chk({tag, " s_ready after pop"}, {s_ready_1, s_ready_0}, 2'b11);
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        logic stale;
        vec_t bp;
        vecs[0] = '{8'h96, 4'd5,  1'b0, 8'hB4, 2'd1, 2'd2, 16'h000B, 16'h0032};
        vecs[1] = '{8'hA5, 4'd0,  1'b0, 8'hA5, 2'd0, 2'd0, 16'h0000, 16'h0000};
        vecs[2] = '{8'hA5, 4'd8,  1'b1, 8'hA5, 2'd0, 2'd0, 16'h0000, 16'h0000};
        vecs[3] = '{8'h12, 4'd4,  1'b0, 8'h21, 2'd2, 2'd2, 16'h0031, 16'h0031};
        vecs[4] = '{8'h12, 4'd4,  1'b1, 8'h21, 2'd2, 2'd2, 16'h00B9, 16'h00B9};
        vecs[5] = '{8'h01, 4'd9,  1'b1, 8'h02, 2'd1, 2'd1, 16'h0009, 16'h0009};
        vecs[6] = '{8'h81, 4'd7,  1'b0, 8'h03, 2'd1, 2'd3, 16'h0009, 16'h0331};
        vecs[7] = '{8'hC3, 4'd6,  1'b1, 8'hF0, 2'd1, 2'd2, 16'h0002, 16'h00BB};
        vecs[8] = '{8'h5A, 4'd3,  1'b1, 8'hD2, 2'd1, 2'd1, 16'h000B, 16'h000B};
        vecs[9] = '{8'h80, 4'd15, 1'b1, 8'h40, 2'd1, 2'd3, 16'h0001, 16'h0BB9};

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_amount = 4'd0;
        s_dir = 1'b0; m_ready = 1'b0;
        #12;
        chk("reset m_valid", {m_valid_1, m_valid_0}, 2'b00);
        chk("reset s_ready", {s_ready_1, s_ready_0}, 2'b11);
        chk("reset m_data", {m_data_1, m_data_0}, 16'h0000);
        chk("reset m_passes", {m_passes_1, m_passes_0}, 4'h0);
        chk("reset rot_mag/dir", {rot_mag_1, rot_dir_1, rot_mag_0, rot_dir_0}, 8'h00);
        chk("reset rot_in", {rot_in_1, rot_in_0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold for five cycles with m_ready low.
        bp = vecs[5];
        run_req(bp, 5, "backpressure");

        // Reset during the first pass of a three-pass request (OPTIMIZE=0).
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h81; s_amount = 4'd7; s_dir = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("rst pre rot_mag opt0", rot_mag_0, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("rst m_valid", {m_valid_1, m_valid_0}, 2'b00);
        chk("rst rot_mag", {rot_mag_1, rot_mag_0}, 6'o00);
        chk("rst s_ready", {s_ready_1, s_ready_0}, 2'b11);
        chk("rst rot_in", {rot_in_1, rot_in_0}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_valid_1 || m_valid_0 || !s_ready_1 || !s_ready_0) stale = 1'b1;
        end
        chk("rst no stale result", stale, 1'b0);
        run_req(vecs[0], 0, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
